// File: rtl/keccak_pkg.sv
// Shared constants and types for the Keccak message padder.
// Domain-separation pad bytes, standard rates, padder state encoding.
package keccak_pkg;

   localparam logic [7:0] KECCAK_PAD    = 8'h01;
   localparam logic [7:0] SHA3_PAD      = 8'h06;
   localparam logic [7:0] SHAKE_PAD     = 8'h1F;
   localparam logic [7:0] LAST_BYTE_PAD = 8'h80;

   localparam int R224 = 1152;
   localparam int R256 = 1088;
   localparam int R384 = 832;
   localparam int R512 = 576;

   typedef enum logic [1:0] {
      ST_ACCEPT = 2'd0,
      ST_PAD    = 2'd1,
      ST_DONE   = 2'd2
   } padder_state_e;

   // byte_num needs at least one bit even for single-byte words
   function automatic int bn_width(input int in_bytes);
      return (in_bytes > 1) ? $clog2(in_bytes) : 1;
   endfunction

endpackage

// File: rtl/keccak_last_word.sv
// Builds the final message word: keeps the first byte_num bytes (byte 0 in the MSBs),
// places the domain pad byte right after them and zeroes the rest.
module keccak_last_word
   import keccak_pkg::*;
#(
   parameter int         IN_BYTES   = 4,
   parameter logic [7:0] DOMAIN_PAD = KECCAK_PAD,
   localparam int        BN_W       = bn_width(IN_BYTES)
) (
   input  logic [8*IN_BYTES-1:0] word_i,
   input  logic [BN_W-1:0]       byte_num_i,
   output logic [8*IN_BYTES-1:0] word_o
);

   always_comb begin
      word_o = '0;
      for (int k = 0; k < IN_BYTES; k++) begin
         if (k < int'(byte_num_i)) begin
            word_o[8*(IN_BYTES-1-k) +: 8] = word_i[8*(IN_BYTES-1-k) +: 8];
         end else if (k == int'(byte_num_i)) begin
            word_o[8*(IN_BYTES-1-k) +: 8] = DOMAIN_PAD;
         end
      end
   end

endmodule

// File: rtl/keccak_padder_p.sv
// Packs message words into rate-sized blocks with pad10*1 padding and hands
// each full block to the permutation core over a full/ack handshake.
//
// state     | meaning
// ST_ACCEPT | taking message words into the next free slot
// ST_PAD    | message ended; zero words fill the remaining slots
// ST_DONE   | padded block consumed; everything ignored until reset
module keccak_padder_p
   import keccak_pkg::*;
#(
   parameter int         IN_BYTES   = 4,
   parameter int         RATE_BITS  = R512,
   parameter logic [7:0] DOMAIN_PAD = KECCAK_PAD,
   localparam int        W          = 8*IN_BYTES,
   localparam int        WORDS      = RATE_BITS / W,
   localparam int        BN_W       = bn_width(IN_BYTES)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [W-1:0]         in_i,
   input  logic                 in_ready_i,
   input  logic                 is_last_i,
   input  logic [BN_W-1:0]      byte_num_i,
   output logic                 buffer_full_o,
   output logic [RATE_BITS-1:0] out_o,
   output logic                 out_ready_o,
   input  logic                 f_ack_i
);

   localparam int               CNT_W    = $clog2(WORDS+1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORDS);

   padder_state_e        state_q, state_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic [RATE_BITS-1:0] blk_q, blk_d;
   logic [W-1:0]         last_word;
   logic [W-1:0]         slot_word;
   logic                 shift;
   logic                 full;
   logic                 pad_tail;

   keccak_last_word #(
      .IN_BYTES   (IN_BYTES),
      .DOMAIN_PAD (DOMAIN_PAD)
   ) u_last_word (
      .word_i     (in_i),
      .byte_num_i (byte_num_i),
      .word_o     (last_word)
   );

   assign full = (count_q == CNT_FULL);

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      blk_d     = blk_q;
      slot_word = '0;
      shift     = 1'b0;
      case (state_q)
         ST_ACCEPT: begin
            if (full) begin
               if (f_ack_i) count_d = '0;
            end else if (in_ready_i) begin
               shift     = 1'b1;
               slot_word = is_last_i ? last_word : in_i;
               if (is_last_i) state_d = ST_PAD;
            end
         end
         ST_PAD: begin
            // a last word landing in the final slot arrives here already full
            if (full) begin
               if (f_ack_i) begin
                  count_d = '0;
                  state_d = ST_DONE;
               end
            end else begin
               shift = 1'b1;
            end
         end
         ST_DONE: ;
         default: state_d = ST_ACCEPT;
      endcase
      if (shift) begin
         blk_d   = (blk_q << W) | RATE_BITS'(slot_word);
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_ACCEPT;
         count_q <= '0;
         blk_q   <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         blk_q   <= blk_d;
      end
   end

   // closing pad bit lives on the output path so it can merge with the domain byte
   assign pad_tail      = (state_q == ST_DONE) || ((state_q == ST_PAD) && full);
   assign out_o         = blk_q | {{(RATE_BITS-8){1'b0}}, (pad_tail ? LAST_BYTE_PAD : 8'h00)};
   assign buffer_full_o = full;
   assign out_ready_o   = full;

endmodule

// File: tb/tb_keccak_padder_p.sv
// Randomized bench for keccak_padder_p: three configurations, expected blocks
// built from byte queues (message ++ domain ++ zeros, last byte | 0x80).
module tb_keccak_padder_p;
   import keccak_pkg::*;

   typedef byte unsigned bq_t[$];

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // channel 0 drives A (4B/576/Keccak) and C (4B/576/SHA3); channel 1 drives B (8B/1088/SHA3)
   logic [31:0]   in0;
   logic [63:0]   in1;
   logic [1:0]    bn0;
   logic [2:0]    bn1;
   logic [1:0]    rdy, last, ack;
   logic          full_a, full_b, full_c, ordy_a, ordy_b, ordy_c;
   logic [575:0]  out_a, out_c;
   logic [1087:0] out_b;

   int n_tests = 0;
   int n_fail  = 0;

   keccak_padder_p #(.IN_BYTES(4), .RATE_BITS(576), .DOMAIN_PAD(KECCAK_PAD)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_i(in0), .in_ready_i(rdy[0]), .is_last_i(last[0]),
      .byte_num_i(bn0), .buffer_full_o(full_a), .out_o(out_a), .out_ready_o(ordy_a), .f_ack_i(ack[0]));

   keccak_padder_p #(.IN_BYTES(4), .RATE_BITS(576), .DOMAIN_PAD(SHA3_PAD)) dut_c (
      .clk(clk), .rst_n(rst_n), .in_i(in0), .in_ready_i(rdy[0]), .is_last_i(last[0]),
      .byte_num_i(bn0), .buffer_full_o(full_c), .out_o(out_c), .out_ready_o(ordy_c), .f_ack_i(ack[0]));

   keccak_padder_p #(.IN_BYTES(8), .RATE_BITS(1088), .DOMAIN_PAD(SHA3_PAD)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_i(in1), .in_ready_i(rdy[1]), .is_last_i(last[1]),
      .byte_num_i(bn1), .buffer_full_o(full_b), .out_o(out_b), .out_ready_o(ordy_b), .f_ack_i(ack[1]));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // inst: 0=A, 1=C, 2=B
   function automatic logic [63:0] obs_word(input int inst, input int s);
      case (inst)
         0:       return 64'(out_a[544-32*s +: 32]);
         1:       return 64'(out_c[544-32*s +: 32]);
         default: return out_b[1024-64*s +: 64];
      endcase
   endfunction

   function automatic logic obs_full(input int inst);
      case (inst)
         0:       return full_a;
         1:       return full_c;
         default: return full_b;
      endcase
   endfunction

   function automatic logic obs_ordy(input int inst);
      case (inst)
         0:       return ordy_a;
         1:       return ordy_c;
         default: return ordy_b;
      endcase
   endfunction

   function automatic logic obs_any(input int inst);
      case (inst)
         0:       return |out_a;
         1:       return |out_c;
         default: return |out_b;
      endcase
   endfunction

   function automatic logic [7:0] dom_of(input int inst);
      return (inst == 0) ? 8'h01 : 8'h06;
   endfunction

   function automatic bq_t pad_block(input bq_t body, input logic [7:0] dom, input int rb);
      bq_t r;
      r = body;
      r.push_back(dom);
      while (r.size() < rb) r.push_back(8'h00);
      r[rb-1] = r[rb-1] | 8'h80;
      return r;
   endfunction

   function automatic bq_t str2q(input string s);
      bq_t r;
      for (int i = 0; i < s.len(); i++) r.push_back(s[i]);
      return r;
   endfunction

   function automatic bq_t rand_q(input int n);
      bq_t r;
      for (int i = 0; i < n; i++) r.push_back(8'($urandom_range(0, 255)));
      return r;
   endfunction

   task automatic check_block(input int inst, input bq_t exp, input string nm);
      int ib;
      logic [63:0] e;
      ib = (inst == 2) ? 8 : 4;
      for (int s = 0; s < exp.size() / ib; s++) begin
         e = '0;
         for (int k = 0; k < ib; k++) e = (e << 8) | 64'(exp[s*ib+k]);
         chk($sformatf("%s.i%0d.w%0d", nm, inst, s), obs_word(inst, s), e);
      end
   endtask

   task automatic check_full(input int ch, input logic exp, input string nm);
      for (int inst = (ch != 0 ? 2 : 0); inst <= (ch != 0 ? 2 : 1); inst++) begin
         chk($sformatf("%s.full%0d", nm, inst), 64'(obs_full(inst)), 64'(exp));
         chk($sformatf("%s.ordy%0d", nm, inst), 64'(obs_ordy(inst)), 64'(exp));
      end
   endtask

   task automatic drive(input int ch, input logic [63:0] w, input logic l, input int bn, input logic a);
      if (ch == 0) begin
         in0 = w[31:0];
         bn0 = 2'(bn);
      end else begin
         in1 = w;
         bn1 = 3'(bn);
      end
      rdy[ch]  = 1'b1;
      last[ch] = l;
      ack[ch]  = a;
      @(negedge clk);
      rdy[ch]  = 1'b0;
      last[ch] = 1'b0;
      ack[ch]  = 1'b0;
   endtask

   task automatic idle(input int ch, input logic a);
      ack[ch] = a;
      @(negedge clk);
      ack[ch] = 1'b0;
   endtask

   task automatic reset_check(input string nm);
      rst_n = 1'b0;
      #2;
      for (int inst = 0; inst < 3; inst++) begin
         chk($sformatf("%s.full%0d", nm, inst), 64'(obs_full(inst)), 64'd0);
         chk($sformatf("%s.ordy%0d", nm, inst), 64'(obs_ordy(inst)), 64'd0);
         chk($sformatf("%s.out%0d", nm, inst), 64'(obs_any(inst)), 64'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic run_msg(input int ch, input bq_t msg, input bit abort, input string nm);
      int ib, words, rb, pos, slot, n, rem, lo, hi;
      bit done;
      bq_t body;
      logic [63:0] w;
      ib    = (ch != 0) ? 8 : 4;
      words = (ch != 0) ? 17 : 18;
      rb    = ib * words;
      lo    = (ch != 0) ? 2 : 0;
      hi    = (ch != 0) ? 2 : 1;
      pos   = 0;
      slot  = 0;
      done  = 1'b0;
      reset_check({nm, ".rst"});
      if (abort) begin
         for (int i = 0; i < 5; i++) drive(ch, {$urandom, $urandom}, 1'b0, 0, 1'b0);
         reset_check({nm, ".abort"});
      end
      while (!done) begin
         rem = msg.size() - pos;
         if ($urandom_range(0, 3) == 0) idle(ch, 1'($urandom_range(0, 1)));
         w = '0;
         for (int k = 0; k < ib; k++)
            w = (w << 8) | ((rem >= ib || k < rem) ? 64'(msg[pos+k]) : 64'($urandom_range(0, 255)));
         if (rem >= ib) begin
            drive(ch, w, 1'b0, 0, 1'b0);
            for (int k = 0; k < ib; k++) body.push_back(msg[pos+k]);
            pos  += ib;
            slot++;
            if (slot == words) begin
               check_full(ch, 1'b1, {nm, ".blk"});
               for (int inst = lo; inst <= hi; inst++) check_block(inst, body, {nm, ".blk"});
               if ($urandom_range(0, 1) == 1) drive(ch, {$urandom, $urandom}, 1'b0, 0, 1'b0);
               if ($urandom_range(0, 1) == 1) drive(ch, {$urandom, $urandom}, 1'b0, 0, 1'b1);
               else idle(ch, 1'b1);
               check_full(ch, 1'b0, {nm, ".ack"});
               body.delete();
               slot = 0;
            end
         end else begin
            drive(ch, w, 1'b1, rem, 1'b0);
            n = 0;
            while (!obs_full(lo) && n < 64) begin
               @(negedge clk);
               n++;
            end
            chk({nm, ".lat"}, 64'(n), 64'(words - 1 - slot));
            check_full(ch, 1'b1, {nm, ".pfull"});
            for (int k = 0; k < rem; k++) body.push_back(msg[pos+k]);
            for (int inst = lo; inst <= hi; inst++)
               check_block(inst, pad_block(body, dom_of(inst), rb), {nm, ".pad"});
            idle(ch, 1'b1);
            check_full(ch, 1'b0, {nm, ".pack"});
            for (int i = 0; i < 3; i++) drive(ch, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 0, 1'b0);
            check_full(ch, 1'b0, {nm, ".done"});
            for (int inst = lo; inst <= hi; inst++)
               check_block(inst, pad_block(body, dom_of(inst), rb), {nm, ".done"});
            done = 1'b1;
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bq_t m;
      int ch;
      rst_n = 1'b1;
      in0 = '0; in1 = '0; bn0 = '0; bn1 = '0;
      rdy = '0; last = '0; ack = '0;
      @(negedge clk);

      run_msg(0, str2q("Hello, world"), 1'b0, "t1");
      chk("t1.hell", obs_word(0, 0), 64'h48656c6c);
      chk("t1.w3a", obs_word(0, 3), 64'h01000000);
      chk("t1.w3c", obs_word(1, 3), 64'h06000000);
      chk("t1.w17a", obs_word(0, 17), 64'h00000080);

      m = rand_q(68);
      m.push_back(8'h61); m.push_back(8'h62); m.push_back(8'h63);
      run_msg(0, m, 1'b0, "t2");
      chk("t2.w17a", obs_word(0, 17), 64'h61626381);
      chk("t2.w17c", obs_word(1, 17), 64'h61626386);

      run_msg(0, rand_q(72), 1'b1, "t3");
      chk("t3.w0a", obs_word(0, 0), 64'h01000000);
      chk("t3.w17a", obs_word(0, 17), 64'h00000080);

      run_msg(1, str2q("ABCDE"), 1'b0, "t6");
      chk("t6.w0", obs_word(2, 0), 64'h4142434445060000);
      chk("t6.w16", obs_word(2, 16), 64'h0000000000000080);

      repeat (16) begin
         ch = int'($urandom_range(0, 1));
         run_msg(ch, rand_q(int'($urandom_range(0, (ch != 0) ? 300 : 200))),
                 $urandom_range(0, 3) == 0, "rnd");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
